osd_spi_loader: RTL and testbench

//  Core-side SPI master that drives the OSD overlay's configuration port (SPI_SCK/SPI_SS3/SPI_DI).

---
 rtl/osd_pkg.sv | 35 +++
 rtl/osd_spi_shifter.sv | 84 ++++++++
 rtl/osd_spi_loader.sv | 175 +++++++++++++++++
 tb/tb_osd_spi_loader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// rtl/osd_pkg.sv - shared ops, command constants and FSM states for the OSD SPI loader
package osd_pkg;

    typedef enum logic [1:0] {
        OSD_OP_DISABLE = 2'd0,
        OSD_OP_ENABLE  = 2'd1,
        OSD_OP_WRITE   = 2'd2,
        OSD_OP_CLEAR   = 2'd3
    } osd_op_e;

    typedef enum logic [2:0] {
        OSD_IDLE,
        OSD_SETUP,
        OSD_CMD,
        OSD_DATA,
        OSD_GAP
    } osd_state_e;

    localparam logic [7:0] OSD_CMD_EN_BASE = 8'h40;
    localparam logic [7:0] OSD_CMD_WR_BASE = 8'h20;
    localparam int         OSD_LINE_BYTES  = 256;

    function automatic logic osd_is_line_op(input osd_op_e op);
        return (op == OSD_OP_WRITE) || (op == OSD_OP_CLEAR);
    endfunction

    function automatic logic [7:0] osd_cmd_byte(input osd_op_e op, input logic [3:0] line);
        case (op)
            OSD_OP_DISABLE: return OSD_CMD_EN_BASE;
            OSD_OP_ENABLE:  return OSD_CMD_EN_BASE | 8'h01;
            default:        return OSD_CMD_WR_BASE | {4'h0, line};
        endcase
    endfunction

endpackage

// File: rtl/osd_spi_shifter.sv
// rtl/osd_spi_shifter.sv - SCK divider and MSB-first byte shifter with back-to-back byte loading
module osd_spi_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       byte_load_i,
    input  logic [7:0] byte_data_i,
    output logic       byte_taken_o,
    output logic       frame_end_o,
    output logic       sck_o,
    output logic       di_o
);

    localparam int DW = $clog2(CLK_DIV) + 1;

    logic          active_q, active_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [6:0]    sr_q, sr_d;
    logic          sck_q, sck_d;
    logic          di_q, di_d;
    logic          phase_end, byte_end;

    assign phase_end    = active_q && (div_q == DW'(CLK_DIV - 1));
    // A new byte is taken exactly when the previous one ends, so SCK never stalls between bytes.
    assign byte_end     = phase_end && sck_q && (bit_q == 3'd0);
    assign byte_taken_o = byte_load_i && (!active_q || byte_end);
    assign frame_end_o  = byte_end && !byte_load_i;
    assign sck_o        = sck_q;
    assign di_o         = di_q;

    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sr_d     = sr_q;
        sck_d    = sck_q;
        di_d     = di_q;
        if (byte_taken_o) begin
            active_d = 1'b1;
            div_d    = '0;
            bit_d    = 3'd7;
            sr_d     = byte_data_i[6:0];
            sck_d    = 1'b0;
            di_d     = byte_data_i[7];
        end else if (phase_end) begin
            div_d = '0;
            if (!sck_q) begin
                sck_d = 1'b1;
            end else begin
                sck_d = 1'b0;
                if (bit_q == 3'd0) begin
                    active_d = 1'b0;
                end else begin
                    bit_d = bit_q - 3'd1;
                    di_d  = sr_q[6];
                    sr_d  = {sr_q[5:0], 1'b0};
                end
            end
        end else if (active_q) begin
            div_d = div_q + DW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= 3'd0;
            sr_q     <= '0;
            sck_q    <= 1'b0;
            di_q     <= 1'b0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
            sck_q    <= sck_d;
            di_q     <= di_d;
        end
    end

endmodule

// File: rtl/osd_spi_loader.sv
// rtl/osd_spi_loader.sv - OSD command-frame SPI master with RAM prefetch; OSD_SPI_CLEAR_EN enables op=3 line clear
import osd_pkg::*;

module osd_spi_loader #(
    parameter int CLK_DIV  = 2,
    parameter int GAP_HALF = 4,
    parameter bit BIG_OSD  = 1'b0
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [3:0] req_line,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       SPI_SCK,
    output logic       SPI_SS3,
    output logic       SPI_DI
);

    localparam int GAP_CYC = GAP_HALF * CLK_DIV;
    localparam int WW      = $clog2(GAP_CYC + CLK_DIV + 1) + 1;

    osd_state_e state_q, state_d;
    osd_op_e    op_q, op_d;
    logic [3:0] line_q, line_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic       ss3_q, ss3_d;
    logic       rd_en_q, rd_en_d;
    logic [7:0] rd_addr_q, rd_addr_d;
    logic       rd_pend_q, rd_pend_d;
    logic [7:0] next_q, next_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       byte_load, byte_taken, frame_end;
    logic [7:0] byte_data, data_src;
    logic       clear_bad, req_bad;

`ifdef OSD_SPI_CLEAR_EN
    assign clear_bad = 1'b0;
    assign data_src  = (op_q == OSD_OP_CLEAR) ? 8'h00 : next_q;
`else
    assign clear_bad = (req_op == 2'd3);
    assign data_src  = next_q;
`endif

    assign req_bad = clear_bad ||
                     (osd_is_line_op(osd_op_e'(req_op)) && !BIG_OSD && req_line[3]);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        line_d     = line_q;
        wait_d     = wait_q;
        byte_cnt_d = byte_cnt_q;
        ss3_d      = ss3_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_pend_d  = rd_en_q;
        next_d     = rd_pend_q ? rd_data : next_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        byte_load  = 1'b0;
        byte_data  = data_src;

        case (state_q)
            OSD_IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = osd_op_e'(req_op);
                        line_d  = req_line;
                        ss3_d   = 1'b0;
                        wait_d  = '0;
                        state_d = OSD_SETUP;
                    end
                end
            end
            OSD_SETUP: begin
                if (wait_q == WW'(CLK_DIV - 1)) begin
                    byte_load = 1'b1;
                    byte_data = osd_cmd_byte(op_q, line_q);
                    state_d   = OSD_CMD;
                    // Byte 0 is fetched while the command's bit 7 is on the wire.
                    rd_en_d   = (op_q == OSD_OP_WRITE);
                    rd_addr_d = 8'd0;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            OSD_CMD, OSD_DATA: begin
                byte_load = (state_q == OSD_CMD) ? osd_is_line_op(op_q)
                                                 : (byte_cnt_q != 8'(OSD_LINE_BYTES - 1));
                if (byte_taken) begin
                    state_d    = OSD_DATA;
                    byte_cnt_d = (state_q == OSD_CMD) ? 8'd0 : byte_cnt_q + 8'd1;
                    rd_addr_d  = rd_addr_q + 8'd1;
                    rd_en_d    = (op_q == OSD_OP_WRITE) && (rd_addr_q != 8'(OSD_LINE_BYTES - 1));
                end
                if (frame_end) begin
                    ss3_d   = 1'b1;
                    wait_d  = '0;
                    state_d = OSD_GAP;
                end
            end
            OSD_GAP: begin
                if (wait_q == WW'(GAP_CYC - 1)) begin
                    done_d  = 1'b1;
                    state_d = OSD_IDLE;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = OSD_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= OSD_IDLE;
            op_q       <= OSD_OP_DISABLE;
            line_q     <= 4'd0;
            wait_q     <= '0;
            byte_cnt_q <= 8'd0;
            ss3_q      <= 1'b1;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= 8'd0;
            rd_pend_q  <= 1'b0;
            next_q     <= 8'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            line_q     <= line_d;
            wait_q     <= wait_d;
            byte_cnt_q <= byte_cnt_d;
            ss3_q      <= ss3_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            rd_pend_q  <= rd_pend_d;
            next_q     <= next_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    osd_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk_i        (clk_sys),
        .reset_i      (reset),
        .byte_load_i  (byte_load),
        .byte_data_i  (byte_data),
        .byte_taken_o (byte_taken),
        .frame_end_o  (frame_end),
        .sck_o        (SPI_SCK),
        .di_o         (SPI_DI)
    );

    assign req_ready = (state_q == OSD_IDLE) && !reset;
    assign busy      = (state_q != OSD_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign SPI_SS3   = ss3_q;

endmodule

// File: tb/tb_osd_spi_loader.sv
// tb/tb_osd_spi_loader.sv - self-checking bench for osd_spi_loader against a byte-stream reference model
module tb_osd_spi_loader;

    localparam int TB_DIV = 2;
    localparam int TB_GAP = 4;
`ifdef OSD_SPI_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       req_valid = 1'b0, req_ready, rd_en, busy, done, err, SPI_SCK, SPI_SS3, SPI_DI;
    logic [1:0] req_op = 2'd0;
    logic [3:0] req_line = 4'd0;
    logic [7:0] rd_addr, rd_data;

    logic       req_valid_b = 1'b0, req_ready_b, rd_en_b, busy_b, done_b, err_b, sck_b, ss3_b, di_b;
    logic [1:0] req_op_b = 2'd0;
    logic [3:0] req_line_b = 4'd0;
    logic [7:0] rd_addr_b, rd_data_b;

    osd_spi_loader #(.CLK_DIV(TB_DIV), .GAP_HALF(TB_GAP), .BIG_OSD(1'b0)) dut (
        .clk_sys(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_line(req_line), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .done(done), .err(err),
        .SPI_SCK(SPI_SCK), .SPI_SS3(SPI_SS3), .SPI_DI(SPI_DI)
    );

    osd_spi_loader #(.CLK_DIV(1), .GAP_HALF(1), .BIG_OSD(1'b1)) dut_big (
        .clk_sys(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_op(req_op_b), .req_line(req_line_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .busy(busy_b), .done(done_b), .err(err_b),
        .SPI_SCK(sck_b), .SPI_SS3(ss3_b), .SPI_DI(di_b)
    );

    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (rd_en === 1'b1)   rd_data   <= ram[rd_addr];
        if (rd_en_b === 1'b1) rd_data_b <= ram[rd_addr_b];
    end

    // Line-side observer: decodes SPI bytes and frame/gap timing
    logic [7:0] rx [$];
    logic [7:0] sh = 8'd0;
    int nb = 0, falls = 0, low_cnt = 0, last_low = 0, since = 0, last_gap = 0;
    int done_cnt = 0, err_cnt = 0, di_viol = 0;
    int rd_cnt [256];
    logic ss3_p = 1'b1, sck_p = 1'b0, di_p = 1'b0;

    initial foreach (rd_cnt[i]) rd_cnt[i] = 0;

    always @(negedge clk) begin
        if (SPI_SS3 === 1'b0 && SPI_SCK === 1'b1 && !sck_p) begin
            sh <= {sh[6:0], SPI_DI};
            if (nb == 7) begin
                rx.push_back({sh[6:0], SPI_DI});
                nb <= 0;
            end else begin
                nb <= nb + 1;
            end
        end else if (SPI_SS3 === 1'b1) begin
            nb <= 0;
        end
        if (SPI_SCK === 1'b1 && sck_p && SPI_DI !== di_p) di_viol <= di_viol + 1;
        if (SPI_SS3 === 1'b0 && ss3_p) falls <= falls + 1;
        if (SPI_SS3 === 1'b1 && !ss3_p) begin
            last_low <= low_cnt;
            low_cnt  <= 0;
            since    <= 0;
        end else begin
            if (SPI_SS3 === 1'b0) low_cnt <= low_cnt + 1;
            since <= since + 1;
        end
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            last_gap <= since + 1;
        end
        if (err === 1'b1) err_cnt <= err_cnt + 1;
        if (rd_en === 1'b1) rd_cnt[rd_addr] <= rd_cnt[rd_addr] + 1;
        ss3_p <= (SPI_SS3 !== 1'b0);
        sck_p <= (SPI_SCK === 1'b1);
        di_p  <= SPI_DI;
    end

    logic [7:0] sh_b = 8'd0, big_cmd = 8'd0;
    int nb_b = 0, cnt_b = 0, last_cnt_b = 0, done_b_cnt = 0, err_b_cnt = 0;
    logic ss3_pb = 1'b1, sck_pb = 1'b0;

    always @(negedge clk) begin
        if (ss3_b === 1'b1) begin
            nb_b  <= 0;
            cnt_b <= 0;
            if (!ss3_pb) last_cnt_b <= cnt_b;
        end else if (sck_b === 1'b1 && !sck_pb) begin
            sh_b <= {sh_b[6:0], di_b};
            if (nb_b == 7) begin
                if (cnt_b == 0) big_cmd <= {sh_b[6:0], di_b};
                cnt_b <= cnt_b + 1;
                nb_b  <= 0;
            end else begin
                nb_b <= nb_b + 1;
            end
        end
        if (done_b === 1'b1) done_b_cnt <= done_b_cnt + 1;
        if (err_b === 1'b1)  err_b_cnt  <= err_b_cnt + 1;
        ss3_pb <= (ss3_b !== 1'b0);
        sck_pb <= (sck_b === 1'b1);
    end

    int passed = 0, total = 0, fails = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [1:0] op, input logic [3:0] line, input bit big);
        if (op == 2'd3 && !CLEAR_EN) return 1'b0;
        if (op[1] && !big && line[3]) return 1'b0;
        return 1'b1;
    endfunction

    // Reference frame: command byte followed by the line payload
    task automatic build_exp(input logic [1:0] op, input logic [3:0] line);
        exp_q.delete();
        case (op)
            2'd0: exp_q.push_back(8'h40);
            2'd1: exp_q.push_back(8'h41);
            default: begin
                exp_q.push_back(8'h20 + 8'(line));
                for (int i = 0; i < 256; i++) exp_q.push_back(op == 2'd2 ? ram[i] : 8'h00);
            end
        endcase
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_req(input logic [1:0] op, input logic [3:0] line);
        int s_rx, s_falls, s_done, s_err, n, mism, bad, reads;
        int snap [256];
        bit ok;
        s_rx = rx.size(); s_falls = falls; s_done = done_cnt; s_err = err_cnt;
        foreach (snap[i]) snap[i] = rd_cnt[i];
        build_exp(op, line);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_line = line;
        @(negedge clk);
        req_valid = 1'b0;
        if (legal(op, line, 1'b0)) begin
            wait_done(s_done, 20000, ok);
            chk($sformatf("done_op%0d_l%0d", op, line), 32'(ok), 32'd1);
            n = rx.size() - s_rx;
            mism = 0;
            for (int i = 0; i < exp_q.size(); i++)
                if (i >= n || rx[s_rx + i] !== exp_q[i]) mism++;
            chk($sformatf("len_op%0d", op), 32'(n), 32'(exp_q.size()));
            chk($sformatf("bytes_op%0d", op), 32'(mism), 32'd0);
            chk($sformatf("ss3_low_op%0d", op), 32'(last_low), 32'(TB_DIV + exp_q.size() * 16 * TB_DIV));
            chk($sformatf("gap_op%0d", op), 32'(last_gap), 32'(TB_GAP * TB_DIV));
            chk($sformatf("frames_op%0d", op), 32'(falls - s_falls), 32'd1);
            chk($sformatf("no_err_op%0d", op), 32'(err_cnt - s_err), 32'd0);
            bad = 0; reads = 0;
            foreach (snap[i]) begin
                if (rd_cnt[i] - snap[i] != 1) bad++;
                reads += rd_cnt[i] - snap[i];
            end
            if (op == 2'd2) begin
                chk("rd_once", 32'(bad), 32'd0);
                chk("rd_addr_wrap", 32'(rd_addr), 32'd0);
            end else begin
                chk($sformatf("rd_none_op%0d", op), 32'(reads), 32'd0);
            end
        end else begin
            repeat (4) @(negedge clk);
            chk($sformatf("err_op%0d_l%0d", op, line), 32'(err_cnt - s_err), 32'd1);
            chk($sformatf("no_frame_op%0d", op), 32'(falls - s_falls), 32'd0);
            chk($sformatf("no_bytes_op%0d", op), 32'(rx.size() - s_rx), 32'd0);
            chk("ready_after_err", 32'(req_ready), 32'd1);
            chk("idle_after_err", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int s_rx, s_falls, s_done, mism;
        bit ok;
        logic [3:0] ln;
        logic [1:0] rop;

        foreach (ram[i]) ram[i] = 8'(i) ^ 8'hA5;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ss3", 32'(SPI_SS3), 32'd1);
        chk("rst_sck", 32'(SPI_SCK), 32'd0);
        chk("rst_di", 32'(SPI_DI), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 32'd1);

        run_req(2'd1, 4'd0);
        run_req(2'd0, 4'd0);
        run_req(2'd2, 4'd3);
        run_req(2'd2, 4'd9);
        run_req(2'd3, 4'd0);

        s_done = done_b_cnt;
        @(negedge clk);
        req_valid_b = 1'b1; req_op_b = 2'd2; req_line_b = 4'd9;
        @(negedge clk);
        req_valid_b = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 10000 && !ok; c++) begin
            @(posedge clk);
            if (done_b_cnt != s_done) ok = 1'b1;
        end
        chk("big_done", 32'(ok), 32'd1);
        chk("big_cmd", 32'(big_cmd), 32'h29);
        chk("big_len", 32'(last_cnt_b), 32'd257);
        chk("big_no_err", 32'(err_b_cnt), 32'd0);

        foreach (ram[i]) ram[i] = 8'($urandom);
        ln = 4'($urandom_range(0, 7));
        build_exp(2'd2, ln);
        s_rx = rx.size();
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd2; req_line = ln;
        @(negedge clk);
        req_valid = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 10000 && !ok; c++) begin
            @(posedge clk);
            if (rx.size() >= s_rx + 101) ok = 1'b1;
        end
        chk("reach_byte100", 32'(ok), 32'd1);
        mism = 0;
        for (int i = 0; i < 101; i++)
            if (s_rx + i >= rx.size() || rx[s_rx + i] !== exp_q[i]) mism++;
        chk("partial_bytes", 32'(mism), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ss3", 32'(SPI_SS3), 32'd1);
        chk("midrst_sck", 32'(SPI_SCK), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        run_req(2'd1, 4'd0);

        s_falls = falls; s_done = done_cnt; s_rx = rx.size();
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd1; req_line = 4'd0;
        wait_done(s_done, 2000, ok);
        chk("hold_done1", 32'(ok), 32'd1);
        chk("hold_one_frame", 32'(falls - s_falls), 32'd1);
        @(negedge clk);
        chk("hold_reaccept", 32'(busy), 32'd1);
        chk("hold_ss3_low", 32'(SPI_SS3), 32'd0);
        req_valid = 1'b0;
        wait_done(s_done + 1, 2000, ok);
        chk("hold_done2", 32'(ok), 32'd1);
        chk("hold_two_frames", 32'(falls - s_falls), 32'd2);
        chk("hold_rx_len", 32'(rx.size() - s_rx), 32'd2);
        if (rx.size() >= s_rx + 2) begin
            chk("hold_rx0", 32'(rx[s_rx]), 32'h41);
            chk("hold_rx1", 32'(rx[s_rx + 1]), 32'h41);
        end

        for (int k = 0; k < 3; k++) begin
            foreach (ram[i]) ram[i] = 8'($urandom);
            rop = 2'($urandom_range(0, 3));
            ln  = 4'($urandom_range(0, 15));
            run_req(rop, ln);
        end

        chk("di_stable_sck_high", 32'(di_viol), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
